id_ex_stage: RTL

- Single-entry pipeline register between instruction decode and the execute-stage ALU.
- Captures decoded operands, translates opcode/funct fields into the 3-bit ALU control code, and selects the second ALU operand (register or immediate).
- Supplies memory and writeback control bits downstream.
- Valid/ready handshake on both sides; flush input turns the held or incoming instruction into a bubble.

---
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode/execute pipeline register with ALU control translation
// Single-entry valid/ready stage; flush turns the held and incoming instruction into a bubble.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            alu_ctrl,
  output logic [XLEN-1:0]       op_a,
  output logic [XLEN-1:0]       op_b,
  output logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [XLEN-1:0]       pc_out,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  branch,
  output logic                  illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [2:0] d_alu;
  logic       d_use_imm;
  logic       d_reg_write;
  logic       d_mem_read;
  logic       d_mem_write;
  logic       d_branch;
  logic       d_illegal;
  logic       accept;

  always_comb begin
    d_alu       = ALU_ADD;
    d_use_imm   = 1'b0;
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_branch    = 1'b0;
    d_illegal   = 1'b0;
    unique case (opcode)
      OP_LOAD: begin
        d_use_imm   = 1'b1;
        d_mem_read  = 1'b1;
        d_reg_write = 1'b1;
      end
      OP_STORE: begin
        d_use_imm   = 1'b1;
        d_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          d_alu    = ALU_SUB;
          d_branch = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_RTYPE, OP_ITYPE: begin
        d_use_imm = (opcode == OP_ITYPE);
        case (funct3)
          3'b000:  d_alu = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  d_alu = ALU_AND;
          3'b110:  d_alu = ALU_OR;
          3'b010:  d_alu = ALU_SLT;
          default: d_illegal = 1'b1;
        endcase
        d_reg_write = !d_illegal;
      end
      default: d_illegal = 1'b1;
    endcase
    // Illegal encodings travel downstream as a plain ADD with no side effects.
    if (d_illegal) begin
      d_alu     = ALU_ADD;
      d_use_imm = 1'b0;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_ctrl   <= ALU_ADD;
      op_a       <= '0;
      op_b       <= '0;
      store_data <= '0;
      rd_out     <= '0;
      pc_out     <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      branch     <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      alu_ctrl   <= d_alu;
      op_a       <= rs1_data;
      op_b       <= d_use_imm ? imm : rs2_data;
      store_data <= rs2_data;
      rd_out     <= rd;
      pc_out     <= pc;
      reg_write  <= d_reg_write;
      mem_read   <= d_mem_read;
      mem_write  <= d_mem_write;
      branch     <= d_branch;
      illegal    <= d_illegal;
    end else if (out_valid && out_ready) begin
      // Control bits drop with out_valid so a bubble never carries side effects.
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      illegal   <= 1'b0;
    end
  end

endmodule
